// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for eight requesters sharing one 8:1 data mux.
// A requester holds the path for at most MAX_HOLD consecutive cycles. The
// grant is released early when the owner drops its request, and ownership
// passes straight to the next requester in circular order.
module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] a,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       y,
    output logic       valid
);

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_r;
    logic [7:0] grant_r;
    logic [2:0] sel_r;
    logic [2:0] ptr_r;
    logic [3:0] cnt_r;

    logic       release_s;
    logic [2:0] search_ptr_s;
    logic [2:0] winner_s;
    logic       any_req_s;

    // First requesting index at or after p, in ascending order modulo 8.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = p + 3'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    endfunction

    // Release decision and winner search. On a release the search starts
    // just past the outgoing owner, so the rotation advances in the same edge.
    always_comb begin
        any_req_s    = |req;
        release_s    = 1'b0;
        search_ptr_s = ptr_r;
        if (state_r == GRANT) begin
            release_s = (req[sel_r] == 1'b0) || (cnt_r == MAX_HOLD_C);
            if (release_s) begin
                search_ptr_s = sel_r + 3'd1;
            end else begin
                search_ptr_s = ptr_r;
            end
        end else begin
            release_s    = 1'b0;
            search_ptr_s = ptr_r;
        end
        winner_s = rr_pick(req, search_ptr_s);
    end

    // Arbitration state machine with registered grant and select.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            grant_r <= 8'h00;
            sel_r   <= 3'd0;
            ptr_r   <= 3'd0;
            cnt_r   <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        state_r <= GRANT;
                        grant_r <= 8'h01 << winner_s;
                        sel_r   <= winner_s;
                        cnt_r   <= 4'd1;
                    end else begin
                        state_r <= IDLE;
                        grant_r <= 8'h00;
                    end
                end
                GRANT: begin
                    if (release_s) begin
                        ptr_r <= search_ptr_s;
                        if (any_req_s) begin
                            state_r <= GRANT;
                            grant_r <= 8'h01 << winner_s;
                            sel_r   <= winner_s;
                            cnt_r   <= 4'd1;
                        end else begin
                            state_r <= IDLE;
                            grant_r <= 8'h00;
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= 8'h00;
                    sel_r   <= 3'd0;
                    ptr_r   <= 3'd0;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    assign grant = grant_r;
    assign sel   = sel_r;
    assign valid = |grant_r;
    assign y     = (|grant_r) ? a[sel_r] : 1'b0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter with MAX_HOLD = 4.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] a;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       y;
    logic       valid;

    int n_checks = 0;
    int n_fail   = 0;

    mux_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .a     (a),
        .grant (grant),
        .sel   (sel),
        .y     (y),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Put the arbiter into a clean reset state with no requests pending.
    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        a   = 8'h00;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'hFF;
        a   = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (grant !== 8'h00 || sel !== 3'd0 || valid !== 1'b0 || y !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: grant=%h sel=%0d valid=%b y=%b, expected 00 0 0 0",
                         grant, sel, valid, y);
            end
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (grant !== 8'h01 || sel !== 3'd0 || y !== 1'b1 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_arb: grant=%h sel=%0d y=%b valid=%b, expected 01 0 1 1",
                     grant, sel, y, valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h20;
        a   = 8'h20;
        step();
        n_checks++;
        if (grant !== 8'h20 || sel !== 3'd5 || valid !== 1'b1 || y !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: grant=%h sel=%0d valid=%b y=%b, expected 20 5 1 1",
                     grant, sel, valid, y);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (grant !== 8'h20 || sel !== 3'd5) begin
                n_fail++;
                $display("FAIL single_regrant cycle %0d: grant=%h sel=%0d, expected 20 5",
                         i, grant, sel);
            end
        end
        a = 8'h00;
        #1;
        n_checks++;
        if (y !== 1'b0) begin
            n_fail++;
            $display("FAIL single_data_zero: y=%b, expected 0", y);
        end
        a = 8'h20;
        #1;
        n_checks++;
        if (y !== 1'b1) begin
            n_fail++;
            $display("FAIL single_data_one: y=%b, expected 1", y);
        end
        req = 8'h00;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (grant !== 8'h00 || sel !== 3'd5 || valid !== 1'b0 || y !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_hold_sel %0d: grant=%h sel=%0d valid=%b y=%b, expected 00 5 0 0",
                         i, grant, sel, valid, y);
            end
        end
        // Pointer sits at 6 after releasing 5, so 7 wins over 0.
        req = 8'h81;
        step();
        n_checks++;
        if (grant !== 8'h80 || sel !== 3'd7) begin
            n_fail++;
            $display("FAIL idle_ptr_search: grant=%h sel=%0d, expected 80 7", grant, sel);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] a_pat;
        logic [2:0] owner;
        logic [7:0] exp_grant;
        do_reset();
        a_pat = 8'hA5;
        a     = a_pat;
        req   = 8'hFF;
        for (int i = 0; i < 36; i++) begin
            step();
            owner     = 3'((i / 4) % 8);
            exp_grant = 8'h01 << owner;
            n_checks++;
            if (grant !== exp_grant || sel !== owner || y !== a_pat[owner] || !$onehot(grant)) begin
                n_fail++;
                $display("FAIL rotation cycle %0d: grant=%h sel=%0d y=%b, expected %h %0d %b",
                         i, grant, sel, y, exp_grant, owner, a_pat[owner]);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req = 8'h03;
        step();
        step();
        n_checks++;
        if (grant !== 8'h01 || sel !== 3'd0) begin
            n_fail++;
            $display("FAIL early_owner: grant=%h sel=%0d, expected 01 0", grant, sel);
        end
        req = 8'h02;
        #1;
        n_checks++;
        if (grant !== 8'h01) begin
            n_fail++;
            $display("FAIL early_persist: grant=%h, expected 01", grant);
        end
        step();
        n_checks++;
        if (grant !== 8'h02 || sel !== 3'd1) begin
            n_fail++;
            $display("FAIL early_handover: grant=%h sel=%0d, expected 02 1", grant, sel);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 8'h40;
        step();
        req = 8'h41;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (grant !== 8'h40 || sel !== 3'd6) begin
                n_fail++;
                $display("FAIL wrap_hold %0d: grant=%h sel=%0d, expected 40 6", i, grant, sel);
            end
        end
        step();
        n_checks++;
        if (grant !== 8'h01 || sel !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_next: grant=%h sel=%0d, expected 01 0", grant, sel);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h08;
        a   = 8'hFF;
        step();
        step();
        n_checks++;
        if (grant !== 8'h08 || sel !== 3'd3) begin
            n_fail++;
            $display("FAIL midrst_owner: grant=%h sel=%0d, expected 08 3", grant, sel);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (grant !== 8'h00 || sel !== 3'd0 || valid !== 1'b0 || y !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_clear: grant=%h sel=%0d valid=%b y=%b, expected 00 0 0 0",
                     grant, sel, valid, y);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (grant !== 8'h08 || sel !== 3'd3) begin
            n_fail++;
            $display("FAIL midrst_regrant: grant=%h sel=%0d, expected 08 3", grant, sel);
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;
        a   = 8'h00;
        test_reset();
        test_single();
        test_rotation();
        test_early_release();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
